// File: rtl/axis_fifo_pkg.sv
// Shared definitions for the AXI4-Stream FIFO: entry layout, default widths
// and the depth helper.
package axis_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 4;

  // One stored beat at the default width: tlast sits above tdata.
  typedef struct packed {
    logic                          tlast;
    logic [DEFAULT_DATA_WIDTH-1:0] tdata;
  } axis_entry_t;

  // Number of entries addressed by an ADDR_WIDTH-bit index.
  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Register array for the FIFO: synchronous write port, asynchronous read port.
module axis_fifo_ram
  import axis_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_DATA_WIDTH + 1,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [fifo_depth(ADDR_WIDTH)];

  // Store the incoming entry on a write fire.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Head entry is presented combinationally.
  always_comb rdata = mem[raddr];

endmodule

// File: rtl/axis_st_fifo.sv
// Synchronous AXI4-Stream FIFO with occupancy and complete-packet counters.
// Optional store-and-forward mode: define AXIS_ST_FIFO_PKT_MODE_EN.
module axis_st_fifo
  import axis_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH:0]   pkt_count
);

  localparam int unsigned        DEPTH   = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE     = 1;

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr, count_next, pkt_q;
  logic                  ready_q, wr_fire, rd_fire;
  logic [DATA_WIDTH:0]   rd_entry;

  axis_fifo_ram #(
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (rd_entry)
  );

  // Handshakes, occupancy and the next-state occupancy used for tready.
  always_comb begin
    wr_fire    = s_axis_tvalid & ready_q;
    rd_fire    = m_axis_tvalid & m_axis_tready;
    count      = wr_ptr - rd_ptr;
    count_next = count + (wr_fire ? ONE : '0) - (rd_fire ? ONE : '0);
  end

  // Pointers advance per fire; tready is !full of the next state, so a read
  // from full frees space only on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ready_q <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + ONE;
      if (rd_fire) rd_ptr <= rd_ptr + ONE;
      ready_q <= (count_next != DEPTH_C);
    end
  end

  // Complete packets held: count tlast beats in minus tlast beats out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_q <= '0;
    end else begin
      case ({wr_fire & s_axis_tlast, rd_fire & m_axis_tlast})
        2'b10:   pkt_q <= pkt_q + ONE;
        2'b01:   pkt_q <= pkt_q - ONE;
        default: pkt_q <= pkt_q;
      endcase
    end
  end

`ifdef AXIS_ST_FIFO_PKT_MODE_EN
  logic release_q;

  // Oversize packet fills the FIFO with no tlast: cut through until its
  // tlast beat is read, otherwise the FIFO would deadlock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      release_q <= 1'b0;
    end else if (rd_fire && m_axis_tlast) begin
      release_q <= 1'b0;
    end else if (count == DEPTH_C && pkt_q == '0) begin
      release_q <= 1'b1;
    end
  end

  // Present data only once a whole packet is stored, or while cutting through.
  always_comb m_axis_tvalid = (count != '0) && ((pkt_q != '0) || release_q);
`else
  // Present data whenever anything is stored.
  always_comb m_axis_tvalid = (count != '0);
`endif

  // Output port mapping.
  always_comb begin
    s_axis_tready = ready_q;
    m_axis_tdata  = rd_entry[DATA_WIDTH-1:0];
    m_axis_tlast  = rd_entry[DATA_WIDTH];
    pkt_count     = pkt_q;
  end

endmodule

// File: tb/tb_axis_st_fifo.sv
// Scoreboard bench for axis_st_fifo: a queue of expected beats is filled on
// every accepted write and drained by a monitor on every read.
module tb_axis_st_fifo;
  import axis_fifo_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
`ifdef AXIS_ST_FIFO_PKT_MODE_EN
  localparam int unsigned WRAP_MAX = 8;
`else
  localparam int unsigned WRAP_MAX = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [AW:0]   count;
  logic [AW:0]   pkt_count;

  axis_st_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .count         (count),
    .pkt_count     (pkt_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: stored beats in order plus the cut-through flag.
  axis_entry_t q[$];
  axis_entry_t head, prev_head;
  bit          rel_m, rel_n, fresh, prev_stall, exp_valid;
  int          pk;

  function automatic int tlast_beats();
    int n = 0;
    foreach (q[i]) if (q[i].tlast) n++;
    return n;
  endfunction

  // Monitor: compare DUT state with the model, then apply this cycle's fires.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_count", count, 0);
      check("rst_pkt_count", pkt_count, 0);
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tready", s_axis_tready, 0);
      q.delete();
      rel_m      = 1'b0;
      fresh      = 1'b1;
      prev_stall = 1'b0;
    end else begin
      pk        = tlast_beats();
      exp_valid = (q.size() != 0);
`ifdef AXIS_ST_FIFO_PKT_MODE_EN
      exp_valid = exp_valid && (pk != 0 || rel_m);
`endif
      check("count", count, q.size());
      check("pkt_count", pkt_count, pk);
      check("tvalid", m_axis_tvalid, exp_valid);
      check("tready", s_axis_tready, fresh ? 1'b0 : (q.size() < DEPTH));
      if (prev_stall)
        check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_head});
      rel_n = rel_m;
      if (q.size() == DEPTH && pk == 0) rel_n = 1'b1;
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          check("read_while_empty", 1'b1, 1'b0);
        end else begin
          head = q.pop_front();
          check("rd_beat", {m_axis_tlast, m_axis_tdata}, head);
          if (head.tlast) rel_n = 1'b0;
        end
      end
      if (s_axis_tvalid && s_axis_tready) q.push_back({s_axis_tlast, s_axis_tdata});
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_head  = {m_axis_tlast, m_axis_tdata};
      rel_m      = rel_n;
      fresh      = 1'b0;
    end
  end

  // Offer one beat and hold it until accepted (bounded).
  task automatic send(input logic [DW-1:0] d, input logic l);
    int n = 0;
    bit ok;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    do begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) check("send_timeout", 1'b0, 1'b1);
    s_axis_tvalid = 1'b0;
  endtask

  // Read everything out (bounded).
  task automatic drain();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (q.size() == 0 && count == 0) break;
    end
    check("drain_done", count, 0);
    @(posedge clk);
    #1;
  endtask

  bit done;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word
    send(32'hA5A5_0001, 1'b1);
    @(negedge clk);
    check("t1_count", count, 1);
    check("t1_head", {m_axis_tlast, m_axis_tdata}, {1'b1, 32'hA5A5_0001});
    drain();

    // Fill to full, release one read
    m_axis_tready = 1'b0;
    for (int i = 0; i < 16; i++) send(32'(i), i == 15);
    @(negedge clk);
    check("t2_full_tready", s_axis_tready, 0);
    check("t2_full_count", count, 16);
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    @(posedge clk);
    #1 m_axis_tready = 1'b0;
    @(negedge clk);
    check("t2_tready_back", s_axis_tready, 1);
    drain();

    // Random stream with random back-pressure
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) send($urandom, (i == 99) || ($urandom_range(3) == 0));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 m_axis_tready = 1'($urandom_range(1));
        end
      end
      begin
        while (!done) begin
          @(negedge clk);
          check("t3_count_le_depth", count <= DEPTH, 1);
        end
      end
    join
    drain();

    // Pointer wrap at full rate
    done = 1'b0;
    m_axis_tready = 1'b1;
    fork
      begin
        for (int i = 0; i < 40; i++) send(32'h4000_0000 + 32'(i), (i % 8) == 7);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          check("t4_count_bound", count <= WRAP_MAX, 1);
        end
      end
    join
    drain();

    // Asynchronous reset at count 7
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) send(32'h7000_0000 + 32'(i), i == 3);
    #2 reset_n = 1'b0;
    #1;
    check("t5_count_async", count, 0);
    check("t5_pkt_async", pkt_count, 0);
    check("t5_tvalid_async", m_axis_tvalid, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1 m_axis_tready = 1'b1;
    send(32'hC0DE_0007, 1'b1);
    drain();

`ifdef AXIS_ST_FIFO_PKT_MODE_EN
    // Packet held until tlast is written, then drains back to back
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) send(32'h5000_0000 + 32'(i), 1'b0);
    @(negedge clk);
    check("t6_held_tvalid", m_axis_tvalid, 0);
    @(posedge clk);
    #1;
    send(32'h5000_0004, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("t6_b2b_count", count, 0);

    // Oversize packet cuts through
    for (int i = 0; i < 20; i++) send(32'h2000_0000 + 32'(i), i == 19);
    drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_st_fifo.md
# axis_st_fifo

Synchronous AXI4-Stream FIFO that sits directly downstream of `two_to_one_st_mux`. It absorbs the mux's `m_axis_*` output and decouples it from the consumer's back-pressure. It stores `tdata` and `tlast` together and reports occupancy. An optional packet mode holds output until a whole packet is buffered.

## Interface
- `DATA_WIDTH`, 32: width of `tdata`.
- `ADDR_WIDTH`, 4: log2 of depth; DEPTH = 2**ADDR_WIDTH (16).

- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  DATA_WIDTH  write data.
- `s_axis_tvalid`  in  1  write valid.
- `s_axis_tready`  out  1  FIFO can accept a word.
- `s_axis_tlast`  in  1  end of packet.
- `m_axis_tdata`  out  DATA_WIDTH  head word.
- `m_axis_tvalid`  out  1  head word available.
- `m_axis_tready`  in  1  consumer accepts.
- `m_axis_tlast`  out  1  tlast of head word.
- `count`  out  ADDR_WIDTH+1  words stored, 0..DEPTH.
- `pkt_count`  out  ADDR_WIDTH+1  complete packets stored.

## Operation
- Write fires when `s_axis_tvalid & s_axis_tready`. Read fires when `m_axis_tvalid & m_axis_tready`.
- `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits wide.
  - Each pointer increments by 1 per fire and wraps naturally at 2**(ADDR_WIDTH+1).
  - The low ADDR_WIDTH bits address the array.
- `count` = `wr_ptr - rd_ptr`, modulo 2**(ADDR_WIDTH+1).
  - Empty when `count == 0`; full when `count == DEPTH`.
- `s_axis_tready` is registered, equal to !full of the next state. There is no write pass-through when full: a read in the same cycle frees space only for the next cycle.
- `m_axis_tdata` and `m_axis_tlast` are read combinationally from the array at `rd_ptr`. They are don't-care while `m_axis_tvalid` = 0.
- Simultaneous write and read with 0 < count < DEPTH: both pointers advance and `count` is unchanged.
- Simultaneous write and read with count == 0 cannot occur, because valid is low when empty.
- `pkt_count` rules:
  - +1 on a write with `tlast` = 1.
  - -1 on a read with `m_axis_tlast` = 1.
  - Both in the same cycle: unchanged.
- Flow, without packet mode: `m_axis_tvalid` = (count != 0).

## Timing
- Reset (`reset_n` low, asynchronous): pointers 0, `count` 0, `pkt_count` 0, `m_axis_tvalid` 0, `s_axis_tready` 0.
- `s_axis_tready` rises on the first `clk` edge after `reset_n` deasserts.
- Reset mid-operation discards all stored words immediately. No partial packet is emitted afterwards.
- Latency: a word accepted at edge N is visible with `m_axis_tvalid` = 1 after edge N, so it can be read at edge N+1.
- Throughput: 1 word/cycle sustained when 0 < count < DEPTH.
- Full: `s_axis_tready` drops on the edge where count reaches DEPTH. It re-rises on the edge after the first read from full.
- Handshake rules:
  - `m_axis_tvalid` never deasserts without a read.
  - `m_axis_tdata` is stable while valid and not ready.

## Configuration
- Macro: `AXIS_ST_FIFO_PKT_MODE_EN`.
- Defined (store-and-forward):
  - `m_axis_tvalid` = (count != 0) & ((`pkt_count` != 0) | `release`).
  - `release` is a sticky register. It sets when count == DEPTH and `pkt_count` == 0, i.e. an oversize packet; the FIFO then cuts through to avoid deadlock.
  - `release` clears on the read of a `tlast` word.
  - Reset value of `release` is 0.
- Undefined:
  - `m_axis_tvalid` = (count != 0).
  - `release` logic is absent.
  - `pkt_count` is still computed and output.

## Structure
- Shared package `axis_fifo_pkg` holds:
  - the entry typedef, packing {tlast, tdata};
  - the default widths;
  - the function computing DEPTH from ADDR_WIDTH.
- One sub-module, `axis_fifo_ram`: DEPTH x (DATA_WIDTH+1) register array with a synchronous write port and an asynchronous read port.
- Pointers, flags and packet logic live in `axis_st_fifo`.

## Test plan
- Reset then single word: write 0xA5A5_0001 with tlast=1 → count=1 after one edge; read returns 0xA5A5_0001 with tlast=1; count returns to 0.
- Fill to full with `m_axis_tready` = 0, 16 words 0..15:
  - `s_axis_tready` = 0 after the 16th accept and count = 16.
  - Release one read → `s_axis_tready` = 1 on the next edge.
  - Drained order is 0..15.
- Continuous stream of 100 words with `m_axis_tready` toggling randomly:
  - no loss or duplication;
  - `tdata`/`tlast` stable while stalled;
  - count never exceeds 16.
- Pointer wrap: 40 words at 1/cycle with `m_axis_tready` = 1 → data in order across two wraps; count ≤ 1 throughout.
- Async reset asserted at count = 7 → count, `pkt_count` and `m_axis_tvalid` read 0 while `reset_n` is low; after release the first output is the next word written.
- With `AXIS_ST_FIFO_PKT_MODE_EN`:
  - A 5-word packet is not presented until its tlast is written, then 5 back-to-back reads.
  - A 20-word packet triggers `release` at count 16 and all 20 words drain.
